perf_counter_bank: RTL

PERF_COUNTER_BANK -- requirements
Module: perf_counter_bank

---
 rtl/perf_counter_bank.sv | 111 +++++++++++
 1 files changed

// File: rtl/perf_counter_bank.sv
// Performance counter bank: per-cycle, retirement-class, branch, stall and external event
// counters with a RUN/HALTED freeze FSM, sticky overflow flags and a registered readout port.
module perf_counter_bank #(
   parameter int WIDTH    = 32,
   parameter int NUM_EXT  = 2,
   parameter int SATURATE = 0,
   localparam int NUM_CH  = 6 + NUM_EXT,
   localparam int SELW    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
   localparam int EXTW    = (NUM_EXT > 0) ? NUM_EXT : 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [5:0]        op,
   input  logic              valid,
   input  logic              stall,
   input  logic              br_taken,
   input  logic              halt,
   input  logic              clear,
   input  logic [EXTW-1:0]   ext_ev,
   input  logic [SELW-1:0]   sel,
   output logic [WIDTH-1:0]  rdata,
   output logic [WIDTH-1:0]  statTC,
   output logic [WIDTH-1:0]  statR,
   output logic [WIDTH-1:0]  statI,
   output logic [WIDTH-1:0]  statJ,
   output logic [NUM_CH-1:0] ovf,
   output logic              halted
);

   // state     | meaning
   // ST_RUN    | counters advance on their events
   // ST_HALTED | all counters frozen; left only via reset or clear
   typedef enum logic {ST_RUN, ST_HALTED} state_t;

   localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   cnt_q [NUM_CH];
   logic [WIDTH-1:0]   cnt_d [NUM_CH];
   logic [NUM_CH-1:0]  ovf_q, ovf_d;
   logic [WIDTH-1:0]   rdata_q, rdata_d;
   logic [NUM_CH-1:0]  inc;
   logic               retire;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ovf_d   = ovf_q;
      inc     = '0;
      retire  = valid && !stall && (state_q == ST_RUN);

      if (state_q == ST_RUN) begin
         inc[0] = 1'b1;
         inc[1] = retire && (op == 6'h00);
         inc[3] = retire && ((op == 6'h02) || (op == 6'h03));
         inc[2] = retire && (op != 6'h00) && (op != 6'h02) && (op != 6'h03);
         inc[4] = br_taken;
         inc[5] = stall;
         for (int k = 0; k < NUM_EXT; k++) begin
            inc[6+k] = ext_ev[k];
         end
         if (halt) state_d = ST_HALTED;
      end

      for (int ch = 0; ch < NUM_CH; ch++) begin
         if (inc[ch]) begin
            if (cnt_q[ch] == ALL_ONES) begin
               ovf_d[ch] = 1'b1;
               cnt_d[ch] = (SATURATE != 0) ? ALL_ONES : '0;
            end else begin
               cnt_d[ch] = cnt_q[ch] + WIDTH'(1);
            end
         end
      end

      // clear overrides halt and every increment of this cycle
      if (clear) begin
         cnt_d   = '{default: '0};
         ovf_d   = '0;
         state_d = ST_RUN;
      end

      rdata_d = '0;
      for (int ch = 0; ch < NUM_CH; ch++) begin
         if (sel == SELW'(ch)) rdata_d = cnt_q[ch];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_RUN;
         cnt_q   <= '{default: '0};
         ovf_q   <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ovf_q   <= ovf_d;
         rdata_q <= rdata_d;
      end
   end

   assign rdata  = rdata_q;
   assign statTC = cnt_q[0];
   assign statR  = cnt_q[1];
   assign statI  = cnt_q[2];
   assign statJ  = cnt_q[3];
   assign ovf    = ovf_q;
   assign halted = (state_q == ST_HALTED);

endmodule
